// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter and its
// matching receivers: FSM state enum, line levels, width helper.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit clock divider: counts 0..CLKS_PER_BIT-1 while enabled and fires
// tick on the terminal count, wrapping to 0. Shared with the receivers.
module bit_timer
  import serial_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = width_of(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Next count: clear wins, terminal count wraps, otherwise advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Bit-serial frame transmitter: start(1), WIDTH data bits MSB first,
// optional even parity, stop(0); each bit held CLKS_PER_BIT clocks.
// Define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load_Valid,
  input  logic [WIDTH-1:0] Data,
  output logic             Load_Ready,
  output logic             Out,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned IW = width_of(WIDTH + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [IW-1:0]    idx_q;
  logic             out_q, busy_q, ready_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             par_q;
`endif

  logic accept, tick, timer_en;

  assign accept    = Load_Valid & ready_q;
  assign timer_en  = (state_q != IDLE);
  assign shift_nxt = shift_q << 1;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (accept),
    .enable (timer_en),
    .tick   (tick)
  );

  // Frame sequencer; line level, busy and ready are registered alongside
  // each state transition so they change on the same edge as the state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      out_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= START;
            shift_q <= Data;
            idx_q   <= '0;
            out_q   <= LINE_START;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= ^Data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            out_q   <= shift_q[WIDTH-1];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              state_q <= PARITY;
              out_q   <= par_q;
`else
              state_q <= STOP;
              out_q   <= LINE_STOP;
`endif
            end else begin
              shift_q <= shift_nxt;
              idx_q   <= idx_q + 1'b1;
              out_q   <= shift_nxt[WIDTH-1];
            end
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            out_q   <= LINE_STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            out_q   <= LINE_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= LINE_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Out        = out_q;
  assign Busy       = busy_q;
  assign Load_Ready = ready_q;
  // Last clock of the stop bit, decoded from registered state and timer.
  assign Done       = (state_q == STOP) && tick;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: two instances (WIDTH=8/CLKS=4 and
// WIDTH=1/CLKS=1) compared cycle by cycle against a frame-sequence model.
module tb_serial_frame_tx;

  localparam int W0 = 8, C0 = 4, W1 = 1, C1 = 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          v0, rdy0, o0, b0, dn0;
  logic [W0-1:0] d0;
  logic          v1, rdy1, o1, b1, dn1;
  logic [W1-1:0] d1;

  serial_frame_tx #(.WIDTH(W0), .CLKS_PER_BIT(C0)) dut0 (
    .Clock(clk), .Reset(rst), .Load_Valid(v0), .Data(d0),
    .Load_Ready(rdy0), .Out(o0), .Busy(b0), .Done(dn0));

  serial_frame_tx #(.WIDTH(W1), .CLKS_PER_BIT(C1)) dut1 (
    .Clock(clk), .Reset(rst), .Load_Valid(v1), .Data(d1),
    .Load_Ready(rdy1), .Out(o1), .Busy(b1), .Done(dn1));

  int checks = 0, passed = 0, fails = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: line level for every clock of the frame, in order.
  task automatic build(input int w, input int c, input logic [31:0] data);
    int ones;
    bit bits[$];
    ones = 0;
    exp_q.delete();
    bits.push_back(1'b1);
    for (int i = w - 1; i >= 0; i--) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (P == 1) bits.push_back(bit'(ones % 2));
    bits.push_back(1'b0);
    foreach (bits[k]) for (int j = 0; j < c; j++) exp_q.push_back(bits[k]);
  endtask

  task automatic sample(input int sel, output logic o, output logic b,
                        output logic r, output logic d);
    if (sel == 0) begin o = o0; b = b0; r = rdy0; d = dn0; end
    else          begin o = o1; b = b1; r = rdy1; d = dn1; end
  endtask

  // Called at a falling edge inside an idle clock; returns at the falling
  // edge of the idle clock that follows the frame.
  task automatic send(input int sel, input logic [31:0] data, input bit hold);
    logic o, b, r, d;
    logic [31:0] m;
    sample(sel, o, b, r, d);
    chk("idle_ready", 32'(r), 32'd1);
    chk("idle_out", 32'(o), 32'd0);
    chk("idle_busy", 32'(b), 32'd0);
    chk("idle_done", 32'(d), 32'd0);
    if (sel == 0) begin m = 32'(data[W0-1:0]); v0 = 1'b1; d0 = data[W0-1:0]; build(W0, C0, m); end
    else          begin m = 32'(data[W1-1:0]); v1 = 1'b1; d1 = data[W1-1:0]; build(W1, C1, m); end
    @(negedge clk);
    if (!hold) begin v0 = 1'b0; v1 = 1'b0; end
    for (int i = 0; i < exp_q.size(); i++) begin
      sample(sel, o, b, r, d);
      chk($sformatf("out[%0d] word %0h", i, m), 32'(o), 32'(exp_q[i]));
      chk("busy", 32'(b), 32'd1);
      chk("ready", 32'(r), 32'd0);
      chk($sformatf("done[%0d]", i), 32'(d), 32'(i == exp_q.size() - 1));
      // Data wiggles mid-frame must not disturb the word in flight.
      if (sel == 0) d0 = W0'($urandom);
      else          d1 = W1'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic o, b, r, d;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out0", 32'(o0), 32'd0);
    chk("rst_busy0", 32'(b0), 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'd1);
    chk("rst_done0", 32'(dn0), 32'd0);
    chk("rst_out1", 32'(o1), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle10_out", 32'(o0), 32'd0);
      chk("idle10_busy", 32'(b0), 32'd0);
      chk("idle10_ready", 32'(rdy0), 32'd1);
      chk("idle10_done", 32'(dn0), 32'd0);
    end

    // Directed words, then random ones.
    send(0, 32'hA5, 1'b0);
    send(0, 32'h07, 1'b0);
    send(0, 32'h00, 1'b0);
    send(0, 32'hFF, 1'b0);
    for (int i = 0; i < 3; i++) send(0, $urandom, 1'b0);

    // Valid held high: frames must be separated by exactly one idle clock.
    for (int i = 0; i < 4; i++) send(0, $urandom, 1'b1);
    v0 = 1'b0;
    @(negedge clk);

    // Minimal configuration: one data bit, one clock per bit.
    send(1, 32'h1, 1'b0);
    send(1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) send(1, $urandom, 1'b1);
    v1 = 1'b0;
    @(negedge clk);

    // Reset during data bit 3 of a frame.
    v0 = 1'b1; d0 = 8'hA5; build(W0, C0, 32'hA5);
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("pre_rst_out[%0d]", i), 32'(o0), 32'(exp_q[i]));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(o0), 32'd0);
    chk("async_rst_busy", 32'(b0), 32'd0);
    chk("async_rst_done", 32'(dn0), 32'd0);
    @(negedge clk);
    chk("rst_hold_done", 32'(dn0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    sample(0, o, b, r, d);
    chk("post_rst_ready", 32'(r), 32'd1);
    chk("post_rst_out", 32'(o), 32'd0);
    chk("post_rst_done", 32'(d), 32'd0);
    send(0, $urandom, 1'b0);
    send(0, 32'h5A, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Bit-serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line. Each frame is a start bit, then the data bits MSB-first, then an optional parity bit, then a stop bit, with every bit held for a programmable number of clocks. It is the driving end of the single-bit serial line consumed by the team's Moore-style serial FSMs. Benches use it as the stimulus source, and SoC glue uses it as the line driver.

## Interface
- WIDTH, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 1, clocks each line bit is held (≥1)

- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high
- Load_Valid  input  1  Data presents a word to send
- Data  input  WIDTH  word to transmit, sampled only on accept
- Load_Ready  output  1  transmitter idle, can accept
- Out  output  1  serial line, registered
- Busy  output  1  frame in progress
- Done  output  1  one-cycle pulse, last clock of stop bit

## Operation
- Line levels:
  - idle = 0
  - start bit = 1
  - stop bit = 0
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - Load_Ready=1, Busy=0, Out=0.
  - Accept = Load_Valid & Load_Ready at a rising edge.
  - On accept: latch Data into the shift register, clear the bit index and the bit timer, go to START.
- **START**
  - Out=1 for CLKS_PER_BIT clocks, then go to DATA.
- **DATA**
  - Out = shift_reg[WIDTH-1]; shift left on each bit-timer tick.
  - WIDTH bits are sent, MSB first.
  - After the last bit, go to PARITY if enabled, else STOP.
- **PARITY** (only with macro)
  - Out = XOR of the latched word (even parity).
  - Held for CLKS_PER_BIT clocks, then go to STOP.
- **STOP**
  - Out=0 for CLKS_PER_BIT clocks.
  - Done=1 on the final clock; next state is IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1; the tick fires at terminal count and the timer wraps to 0.
  - Width is clog2(CLKS_PER_BIT), minimum 1.
- Bit index width is clog2(WIDTH+1); it must not wrap within a frame.
- Load_Valid outside IDLE is ignored. The caller holds Valid until accepted, and no data is lost.
- Unreachable state encodings return to IDLE with Out=0.

## Timing
- Reset values:
  - Out=0, Busy=0, Done=0, Load_Ready=1
  - state=IDLE, shift register and counters 0
- Reset asserted mid-frame:
  - Out drops to 0 asynchronously and the frame is abandoned.
  - No Done pulse.
  - Ready is high in the first clock after deassertion.
- Accept at edge T:
  - Out=1 (start bit) and Busy=1 from T+1.
  - Load_Ready=0 from T+1.
- Frame length F = (2 + WIDTH + P) × CLKS_PER_BIT clocks, where P = 1 with parity, else 0.
- Done is high during clock T+F. IDLE with Load_Ready=1 follows at T+F+1.
- Back-to-back throughput: one frame per F+1 clocks, i.e. a mandatory single idle-0 clock between frames.
- All outputs are registered or decoded from registered state only. There is no combinational path from Load_Valid or Data to any output.

## Configuration
- SERIAL_FRAME_TX_PARITY_EN defined:
  - PARITY state exists and P=1.
  - Even-parity bit inserted between the last data bit and the stop bit.
- Undefined:
  - PARITY state, the parity register and the XOR logic are compiled out.
  - DATA goes directly to STOP, and P=0.

## Structure
- Package serial_frame_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - constants LINE_IDLE=0, LINE_START=1, LINE_STOP=0
  - a clog2-based width helper function
- Sub-module bit_timer, which is reusable by the matching receivers:
  - inputs: Clock, Reset, clear, enable
  - output: tick
  - parameter: CLKS_PER_BIT

## Test plan
- Reset, then idle 10 clocks -> Out=0, Busy=0, Load_Ready=1, Done=0 throughout.
- WIDTH=8, CLKS_PER_BIT=4, no parity, Data=8'hA5 accepted at T -> Out, 4 clocks per bit, = 1,1,0,1,0,0,1,0,1,0; Done at T+40; Ready at T+41.
- Same with SERIAL_FRAME_TX_PARITY_EN, Data=8'hA5 then 8'h07 -> parity bits 0 then 1; F=44; Done at T+44.
- Load_Valid held high continuously with a new Data each accept -> frames separated by exactly one idle-0 clock; Data changes while Busy have no effect on the current frame.
- Reset pulsed during data bit 3 of a frame -> Out=0 immediately, no Done; the next accept transmits its new word from the start bit.
- CLKS_PER_BIT=1, WIDTH=1, Data=1 -> Out=1,1,0 on consecutive clocks; Done on the 3rd clock.
